abs_offset_pipe: RTL and testbench
==================================

ABS_OFFSET_PIPE -- requirements
Module: abs_offset_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sample width; legal range 8..30.
REQ-002 Parameter NUM_CH, default 2, number of parallel channels; legal range 1..8.
REQ-003 Port clk_i  in  1  sole clock; all logic on rising edge.
REQ-004 Port rst_i  in  1  reset, synchronous, active-high.
REQ-005 Port gpio0_i  in  32  bits [DATA_WIDTH-1:0] carry the signed offset; upper bits ignored.
REQ-006 Port gpio1_i  in  32  bits [1:0] carry mode (0 pass, 1 abs, 2 half-wave, 3 negated-abs); bit [2] is peak clear; other bits ignored.
REQ-007 Port adc_data_i  in  NUM_CH*DATA_WIDTH  packed two's-complement samples; channel k at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port valid_i  in  1  qualifies adc_data_i for all channels.
REQ-009 Port data_o  out  NUM_CH*DATA_WIDTH  packed signed results, same packing as adc_data_i.
REQ-010 Port valid_o  out  1  qualifies data_o.
REQ-011 Port sat_o  out  NUM_CH  per-channel flag: the sample on data_o was clipped.
REQ-012 Port peak_o  out  NUM_CH*DATA_WIDTH  per-channel peak magnitude (only with ABS_PEAK_HOLD_EN).

Function
REQ-013 Stage 1: per channel, sum = sext(sample) + sext(offset) at DATA_WIDTH+1 bits, saturated to [-2^(W-1), 2^(W-1)-1]; clip sets stage-1 sat bit.
REQ-014 Stage 2: mode applied to saturated sum: pass = sum; abs = |sum|; half-wave = max(sum,0); negated-abs = -|sum|.
REQ-015 |-2^(W-1)| shall clamp to 2^(W-1)-1 and set sat for that sample; negated-abs of -2^(W-1) is -2^(W-1) with no additional clip.
REQ-016 Latency is exactly 2 clk_i cycles from valid_i high to valid_o high; throughput one sample per cycle.
REQ-017 valid_o is valid_i delayed 2 cycles; data_o and sat_o update only on cycles where the corresponding stage valid is high, otherwise hold.
REQ-018 Offset and mode are sampled into stage 1 with the data; a change mid-stream affects only samples entering on or after the change cycle.
REQ-019 Channels are independent; one channel saturating has no effect on others.
REQ-020 No backpressure; the block always accepts input.

Reset
REQ-021 When rst_i high at a clock edge: valid pipeline, data_o, sat_o and peak_o become 0 on that edge.
REQ-022 Samples in flight at reset are discarded; valid_o is 0 for the 2 cycles after rst_i deasserts unless valid_i was high in them.

Configuration
REQ-023 Macro ABS_PEAK_HOLD_EN: when defined, per channel peak register = max(peak, |stage-2 result|) on each valid_o cycle; peak clamp per REQ-015.
REQ-024 With ABS_PEAK_HOLD_EN, gpio1_i[2] high clears all peaks to 0 that cycle; clear wins over a simultaneous update (that sample is not captured).
REQ-025 Without ABS_PEAK_HOLD_EN, peak_o is tied to 0 and no peak registers exist; gpio1_i[2] ignored.

Structure
REQ-026 Shared package abs_pkg holds the mode encoding constants (MODE_PASS, MODE_ABS, MODE_HALF, MODE_NABS) and the saturation helper function.
REQ-027 Per-channel datapath (stages 1-2, sat, peak) is sub-module abs_offset_lane, instantiated NUM_CH times; top holds only shared valid pipeline and gpio decode.

Verification
REQ-028 W=16, offset=0x0010, mode abs, sample 0xFF00 (-256) with valid_i -> 2 cycles later data_o=0x00F0, sat_o=0, valid_o=1.
REQ-029 offset=0x7FFF, sample 0x0001, mode pass -> data_o=0x7FFF, sat_o=1; offset=0x8000, sample 0xFFFF, mode abs -> data_o=0x7FFF, sat_o=1.
REQ-030 Mode half-wave, samples -5,+5 back-to-back, offset 0 -> data_o 0 then 5 on consecutive cycles; valid_o high both cycles.
REQ-031 Stream with valid_i toggling 1,0,1; mode switched pass->abs on second valid sample -> valid_o mirrors pattern 2 cycles late; first output signed, second magnitude.
REQ-032 rst_i asserted one cycle while two samples in flight -> valid_o, data_o, sat_o, peak_o 0 next cycle; no stale sample emerges.
REQ-033 ABS_PEAK_HOLD_EN, ch0 magnitudes 3,9,4 -> peak_o ch0=9; gpio1_i[2] high with sample 20 same cycle -> peak 0, next sample 2 -> peak 2.

Source files
------------

// File: rtl/abs_pkg.sv
// Shared definitions for the offset/abs pipeline: mode encoding and the
// signed saturation helper used by every lane.
package abs_pkg;

   typedef enum logic [1:0] {
      MODE_PASS = 2'd0,
      MODE_ABS  = 2'd1,
      MODE_HALF = 2'd2,
      MODE_NABS = 2'd3
   } mode_e;

   // Clip a sign-extended value into the signed range of a width-bit word.
   function automatic logic signed [31:0] sat_clip(input logic signed [31:0] value,
                                                   input int               width);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (width - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      if (value > hi) begin
         return hi;
      end else if (value < lo) begin
         return lo;
      end
      return value;
   endfunction

endpackage

// File: rtl/abs_offset_lane.sv
// One channel of the pipeline: saturating offset add, mode shaping and sat flag.
// Peak-magnitude hold is built only when ABS_PEAK_HOLD_EN is defined.
module abs_offset_lane
   import abs_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         in_valid,
   input  logic                         mid_valid,
   input  logic signed [DATA_WIDTH-1:0] sample,
   input  logic signed [DATA_WIDTH-1:0] offset,
   input  mode_e                        mode,
   input  logic                         peak_clear,
   output logic signed [DATA_WIDTH-1:0] data,
   output logic                         sat,
   output logic        [DATA_WIDTH-1:0] peak
);

   localparam logic signed [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic signed [DATA_WIDTH:0]   sum_wide;
   logic signed [31:0]           sum_ext;
   logic signed [31:0]           sum_sat;
   logic                         clip;

   logic signed [DATA_WIDTH-1:0] s1_sum;
   logic                         s1_sat;
   mode_e                        s1_mode;

   logic                         is_min;
   logic signed [DATA_WIDTH-1:0] mag;
   logic signed [DATA_WIDTH-1:0] res;
   logic                         res_sat;

   assign sum_wide = {sample[DATA_WIDTH-1], sample} + {offset[DATA_WIDTH-1], offset};
   assign sum_ext  = {{(31-DATA_WIDTH){sum_wide[DATA_WIDTH]}}, sum_wide};
   assign sum_sat  = sat_clip(sum_ext, DATA_WIDTH);
   assign clip     = (sum_sat != sum_ext);

   // Mode travels with the sample so a mid-stream change only hits later samples.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_sum  <= '0;
         s1_sat  <= 1'b0;
         s1_mode <= MODE_PASS;
      end else if (in_valid) begin
         s1_sum  <= sum_sat[DATA_WIDTH-1:0];
         s1_sat  <= clip;
         s1_mode <= mode;
      end
   end

   // The most negative value has no positive twin, so its magnitude clamps.
   always_comb begin
      is_min  = (s1_sum == MIN_VAL);
      mag     = is_min ? MAX_VAL : (s1_sum[DATA_WIDTH-1] ? -s1_sum : s1_sum);
      res     = s1_sum;
      res_sat = s1_sat;
      case (s1_mode)
         MODE_PASS: res = s1_sum;
         MODE_ABS: begin
            res     = mag;
            res_sat = s1_sat | is_min;
         end
         MODE_HALF: res = s1_sum[DATA_WIDTH-1] ? '0 : s1_sum;
         MODE_NABS: res = is_min ? MIN_VAL : -mag;
         default:   res = s1_sum;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data <= '0;
         sat  <= 1'b0;
      end else if (mid_valid) begin
         data <= res;
         sat  <= res_sat;
      end
   end

`ifdef ABS_PEAK_HOLD_EN
   logic [DATA_WIDTH-1:0] res_mag;
   logic [DATA_WIDTH-1:0] peak_q;

   assign res_mag = (res == MIN_VAL) ? MAX_VAL : (res[DATA_WIDTH-1] ? -res : res);

   // Peak tracks the value landing on data; a clear on the same edge wins.
   always_ff @(posedge clk_i) begin
      if (rst_i || peak_clear) begin
         peak_q <= '0;
      end else if (mid_valid && (res_mag > peak_q)) begin
         peak_q <= res_mag;
      end
   end

   assign peak = peak_q;
`else
   logic unused_peak_clear;
   assign unused_peak_clear = peak_clear;
   assign peak              = '0;
`endif

endmodule

// File: rtl/abs_offset_pipe.sv
// Two-stage offset/abs pipeline over NUM_CH parallel lanes; top holds the shared
// valid pipeline and GPIO decode. Optional peak hold: define ABS_PEAK_HOLD_EN.
module abs_offset_pipe
   import abs_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CH     = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [31:0]                    gpio0_i,
   input  logic [31:0]                    gpio1_i,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   adc_data_i,
   input  logic                           valid_i,
   output logic [NUM_CH*DATA_WIDTH-1:0]   data_o,
   output logic                           valid_o,
   output logic [NUM_CH-1:0]              sat_o,
   output logic [NUM_CH*DATA_WIDTH-1:0]   peak_o
);

   logic [DATA_WIDTH-1:0] offset;
   mode_e                 mode;
   logic                  peak_clear;
   logic                  valid_s1;
   logic                  valid_s2;
   logic                  unused_gpio;

   assign offset      = gpio0_i[DATA_WIDTH-1:0];
   assign mode        = mode_e'(gpio1_i[1:0]);
   assign peak_clear  = gpio1_i[2];
   assign unused_gpio = ^{gpio0_i[31:DATA_WIDTH], gpio1_i[31:3]};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_s1 <= 1'b0;
         valid_s2 <= 1'b0;
      end else begin
         valid_s1 <= valid_i;
         valid_s2 <= valid_s1;
      end
   end

   assign valid_o = valid_s2;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      abs_offset_lane #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_lane (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .in_valid   (valid_i),
         .mid_valid  (valid_s1),
         .sample     (adc_data_i[k*DATA_WIDTH +: DATA_WIDTH]),
         .offset     (offset),
         .mode       (mode),
         .peak_clear (peak_clear),
         .data       (data_o[k*DATA_WIDTH +: DATA_WIDTH]),
         .sat        (sat_o[k]),
         .peak       (peak_o[k*DATA_WIDTH +: DATA_WIDTH])
      );
   end

endmodule

// File: tb/tb_abs_offset_pipe.sv
// Self-checking bench for abs_offset_pipe (W=16, two channels): directed
// scenarios followed by a random stream, against an integer reference model.
module tb_abs_offset_pipe;

   localparam int W    = 16;
   localparam int NCH  = 2;
   localparam int MAXV = 32767;
   localparam int MINV = -32768;

   logic               clk_i = 1'b0;
   logic               rst_i = 1'b1;
   logic [31:0]        gpio0_i = '0;
   logic [31:0]        gpio1_i = '0;
   logic [NCH*W-1:0]   adc_data_i = '0;
   logic               valid_i = 1'b0;
   logic [NCH*W-1:0]   data_o;
   logic               valid_o;
   logic [NCH-1:0]     sat_o;
   logic [NCH*W-1:0]   peak_o;

   int vectors     = 0;
   int miscompares = 0;
   int step_no     = 0;

   // Model state: the sample accepted last edge, and what the outputs should hold now.
   bit pend_valid = 0;
   int pend_res [NCH];
   bit pend_sat [NCH];
   bit exp_valid = 0;
   int exp_data [NCH];
   bit exp_sat  [NCH];
   int exp_peak [NCH];

   abs_offset_pipe #(
      .DATA_WIDTH (W),
      .NUM_CH     (NCH)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .gpio0_i    (gpio0_i),
      .gpio1_i    (gpio1_i),
      .adc_data_i (adc_data_i),
      .valid_i    (valid_i),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .sat_o      (sat_o),
      .peak_o     (peak_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic void lane_model(input int s, input int off, input int mode,
                                      output int res, output bit sat);
      int sum;
      sum = s + off;
      sat = 0;
      if (sum > MAXV) begin
         sum = MAXV;
         sat = 1;
      end else if (sum < MINV) begin
         sum = MINV;
         sat = 1;
      end
      case (mode)
         0: res = sum;
         1: begin
            res = (sum < 0) ? -sum : sum;
            if (res > MAXV) begin
               res = MAXV;
               sat = 1;
            end
         end
         2: res = (sum < 0) ? 0 : sum;
         default: res = (sum < 0) ? sum : -sum;
      endcase
   endfunction

   function automatic int mag_clamp(input int v);
      int m;
      m = (v < 0) ? -v : v;
      return (m > MAXV) ? MAXV : m;
   endfunction

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s step %0d: observed 0x%0h expected 0x%0h", name, step_no, got, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [W-1:0] exp_word;
      check_val({tag, " valid_o"}, {31'b0, valid_o}, {31'b0, exp_valid});
      for (int ch = 0; ch < NCH; ch++) begin
         exp_word = W'(exp_data[ch]);
         check_val($sformatf("%s data_o[%0d]", tag, ch), {16'b0, data_o[ch*W +: W]}, {16'b0, exp_word});
         check_val($sformatf("%s sat_o[%0d]", tag, ch), {31'b0, sat_o[ch]}, {31'b0, exp_sat[ch]});
         exp_word = W'(exp_peak[ch]);
         check_val($sformatf("%s peak_o[%0d]", tag, ch), {16'b0, peak_o[ch*W +: W]}, {16'b0, exp_word});
      end
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then compare.
   task automatic applyStimulus(input string tag, input int s0, input int s1, input int off,
                                input int mode, input bit vld, input bit clr, input bit rst);
      int smp [NCH];
      smp[0] = s0;
      smp[1] = s1;
      @(negedge clk_i);
      adc_data_i = {W'(s1), W'(s0)};
      gpio0_i    = {16'hA5A5, W'(off)};
      gpio1_i    = {29'h1555_5555, clr, 2'(mode)};
      valid_i    = vld;
      rst_i      = rst;
      @(posedge clk_i);
      #1;
      step_no++;
      if (rst) begin
         pend_valid = 0;
         exp_valid  = 0;
         for (int ch = 0; ch < NCH; ch++) begin
            exp_data[ch] = 0;
            exp_sat[ch]  = 0;
            exp_peak[ch] = 0;
         end
      end else begin
         exp_valid = pend_valid;
         for (int ch = 0; ch < NCH; ch++) begin
            if (pend_valid) begin
               exp_data[ch] = pend_res[ch];
               exp_sat[ch]  = pend_sat[ch];
`ifdef ABS_PEAK_HOLD_EN
               if (mag_clamp(pend_res[ch]) > exp_peak[ch]) exp_peak[ch] = mag_clamp(pend_res[ch]);
`endif
            end
`ifdef ABS_PEAK_HOLD_EN
            if (clr) exp_peak[ch] = 0;
`endif
         end
         pend_valid = vld;
         if (vld) begin
            for (int ch = 0; ch < NCH; ch++) lane_model(smp[ch], off, mode, pend_res[ch], pend_sat[ch]);
         end
      end
      checkOutput(tag);
   endtask

   initial begin
      for (int ch = 0; ch < NCH; ch++) begin
         pend_res[ch] = 0;
         pend_sat[ch] = 0;
         exp_data[ch] = 0;
         exp_sat[ch]  = 0;
         exp_peak[ch] = 0;
      end

      applyStimulus("reset", 0, 0, 0, 0, 0, 0, 1);
      applyStimulus("reset", 123, -45, 7, 1, 1, 0, 1);

      // Offset 0x10 on -256 in abs mode gives 0xF0 two cycles on.
      applyStimulus("abs_basic", -256, 100, 16, 1, 1, 0, 0);
      applyStimulus("abs_basic", 0, 0, 16, 1, 0, 0, 0);
      applyStimulus("abs_basic", 0, 0, 16, 1, 0, 0, 0);

      applyStimulus("sat_pass", 1, -3, 32767, 0, 1, 0, 0);
      applyStimulus("sat_abs", -1, 5, -32768, 1, 1, 0, 0);
      applyStimulus("sat_min_abs", -32768, 10, -32768, 1, 1, 0, 0);
      applyStimulus("nabs_min", -32768, 10, 0, 3, 1, 0, 0);
      applyStimulus("nabs_pos", 1234, -77, 0, 3, 1, 0, 0);
      applyStimulus("flush", 0, 0, 0, 0, 0, 0, 0);
      applyStimulus("flush", 0, 0, 0, 0, 0, 0, 0);

      applyStimulus("half", -5, 8, 0, 2, 1, 0, 0);
      applyStimulus("half", 5, -8, 0, 2, 1, 0, 0);
      applyStimulus("half", 0, 0, 0, 2, 0, 0, 0);
      applyStimulus("half", 0, 0, 0, 2, 0, 0, 0);

      applyStimulus("mode_sw", -7, 300, 0, 0, 1, 0, 0);
      applyStimulus("mode_sw", 999, 999, 0, 1, 0, 0, 0);
      applyStimulus("mode_sw", -7, -300, 0, 1, 1, 0, 0);
      applyStimulus("mode_sw", 0, 0, 0, 1, 0, 0, 0);
      applyStimulus("mode_sw", 0, 0, 0, 1, 0, 0, 0);

      applyStimulus("peak", 0, 0, 0, 1, 0, 1, 0);
      applyStimulus("peak", -3, 1, 0, 1, 1, 0, 0);
      applyStimulus("peak", 9, 2, 0, 1, 1, 0, 0);
      applyStimulus("peak", -4, 1, 0, 1, 1, 0, 0);
      applyStimulus("peak", 20, 6, 0, 1, 1, 0, 0);
      applyStimulus("peak_clr", 2, 1, 0, 1, 1, 1, 0);
      applyStimulus("peak", 0, 0, 0, 1, 0, 0, 0);
      applyStimulus("peak", 0, 0, 0, 1, 0, 0, 0);

      applyStimulus("inflight", 1000, -2000, 5, 0, 1, 0, 0);
      applyStimulus("inflight", 3000, -4000, 5, 0, 1, 0, 0);
      applyStimulus("inflight_rst", 50, 60, 5, 0, 0, 0, 1);
      applyStimulus("after_rst", 0, 0, 0, 0, 0, 0, 0);
      applyStimulus("after_rst", 0, 0, 0, 0, 0, 0, 0);
      applyStimulus("after_rst", 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 300; i++) begin
         applyStimulus("random",
                       int'($urandom_range(65535)) - 32768,
                       int'($urandom_range(65535)) - 32768,
                       ($urandom_range(3) == 0) ? int'($urandom_range(65535)) - 32768
                                                : int'($urandom_range(200)) - 100,
                       int'($urandom_range(3)),
                       ($urandom_range(3) != 0),
                       ($urandom_range(15) == 0),
                       ($urandom_range(63) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
